// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: one requester at a time owns a shared resource until it
// finishes, aborts, or exceeds the hold limit; the pointer then moves past the old owner.
module rr_grant_sched #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COUNT_WIDTH = $clog2(WIDTH),
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_req,
    input  logic                   in_done,
    output logic [COUNT_WIDTH-1:0] o_grant,
    output logic [WIDTH-1:0]       o_grant_oh,
    output logic                   o_valid,
    output logic                   o_empty,
    output logic                   o_timeout
);

    typedef enum logic {
        StIdle,
        StBusy
    } state_t;

    localparam logic [7:0]             HoldLast = 8'(MAX_HOLD - 1);
    localparam logic [COUNT_WIDTH-1:0] One      = COUNT_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [COUNT_WIDTH-1:0]   r_ptr;
    logic [COUNT_WIDTH-1:0]   w_ptr_next;
    logic [COUNT_WIDTH-1:0]   r_grant;
    logic [COUNT_WIDTH-1:0]   w_grant_next;
    logic [WIDTH-1:0]         r_grant_oh;
    logic [WIDTH-1:0]         w_grant_oh_next;
    logic [7:0]               r_hold;
    logic [7:0]               w_hold_next;
    logic                     r_timeout;
    logic                     w_timeout_next;

    logic                     w_hold_hit;
    logic                     w_abort;
    logic                     w_release;
    logic [COUNT_WIDTH-1:0]   w_search;
    logic [COUNT_WIDTH-1:0]   w_idx;
    logic [COUNT_WIDTH-1:0]   w_win;
    logic                     w_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_hold     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_grant    <= w_grant_next;
            r_grant_oh <= w_grant_oh_next;
            r_hold     <= w_hold_next;
            r_timeout  <= w_timeout_next;
        end
    end

    // On release the search already starts past the old owner, so it re-wins only last.
    always_comb begin
        w_hold_hit = (r_hold == HoldLast);
        w_abort    = ~in_req[r_grant];
        w_release  = (r_state == StBusy) && (in_done || w_abort || w_hold_hit);
        w_search   = w_release ? (r_grant + One) : r_ptr;
        w_found    = 1'b0;
        w_win      = '0;
        w_idx      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_idx = w_search + COUNT_WIDTH'(i);
            if (!w_found && in_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_grant_next    = r_grant;
        w_grant_oh_next = r_grant_oh;
        w_hold_next     = r_hold;
        w_timeout_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_next    = StBusy;
                    w_grant_next    = w_win;
                    w_grant_oh_next = WIDTH'(1) << w_win;
                    w_hold_next     = '0;
                end
            end
            StBusy: begin
                if (w_release) begin
                    w_ptr_next     = r_grant + One;
                    // A completion or abort in the same cycle outranks the hold limit.
                    w_timeout_next = w_hold_hit && !in_done && !w_abort;
                    w_hold_next    = '0;
                    if (w_found) begin
                        w_grant_next    = w_win;
                        w_grant_oh_next = WIDTH'(1) << w_win;
                    end else begin
                        w_state_next    = StIdle;
                        w_grant_next    = '0;
                        w_grant_oh_next = '0;
                    end
                end else if (r_hold != 8'hFF) begin
                    w_hold_next = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_grant    = r_grant;
    assign o_grant_oh = r_grant_oh;
    assign o_valid    = (r_state == StBusy);
    assign o_empty    = (r_state == StIdle);
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched (WIDTH 8, MAX_HOLD 4); expectations are queued per
// step and checked one edge later.
module tb_rr_grant_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_req;
    logic       in_done;
    logic [2:0] o_grant;
    logic [7:0] o_grant_oh;
    logic       o_valid;
    logic       o_empty;
    logic       o_timeout;

    typedef struct {
        string      tag;
        logic       v;
        logic [2:0] g;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    rr_grant_sched #(
        .WIDTH   (8),
        .MAX_HOLD(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_done   (in_done),
        .o_grant   (o_grant),
        .o_grant_oh(o_grant_oh),
        .o_valid   (o_valid),
        .o_empty   (o_empty),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check();
        exp_t       e;
        logic [7:0] oh;
        logic [7:0] one;
        e   = q.pop_front();
        one = 8'd1;
        oh  = e.v ? (one << e.g) : 8'd0;
        n_cmp++;
        assert (o_valid === e.v) else begin
            n_fail++;
            $error("FAIL %s valid: got %b want %b", e.tag, o_valid, e.v);
        end
        n_cmp++;
        assert (o_empty === ~e.v) else begin
            n_fail++;
            $error("FAIL %s empty: got %b want %b", e.tag, o_empty, ~e.v);
        end
        n_cmp++;
        assert (o_grant === e.g) else begin
            n_fail++;
            $error("FAIL %s grant: got %0d want %0d", e.tag, o_grant, e.g);
        end
        n_cmp++;
        assert (o_grant_oh === oh) else begin
            n_fail++;
            $error("FAIL %s grant_oh: got %h want %h", e.tag, o_grant_oh, oh);
        end
        n_cmp++;
        assert (o_timeout === e.to) else begin
            n_fail++;
            $error("FAIL %s timeout: got %b want %b", e.tag, o_timeout, e.to);
        end
    endtask

    task automatic step(input string tag, input logic rn, input logic [7:0] req,
                        input logic d, input logic ev, input logic [2:0] eg,
                        input logic eto);
        exp_t e;
        rst_n   = rn;
        in_req  = req;
        in_done = d;
        e.tag = tag;
        e.v   = ev;
        e.g   = eg;
        e.to  = eto;
        q.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        rst_n   = 1'b0;
        in_req  = '0;
        in_done = 1'b0;
        #1;
        step("rst0", 0, 8'h00, 0, 0, 3'd0, 0);
        step("rst1", 0, 8'hFF, 1, 0, 3'd0, 0);

        // First grant from ptr 0, then done hands over without a bubble.
        step("first", 1, 8'h24, 0, 1, 3'd2, 0);
        step("hand5", 1, 8'h24, 1, 1, 3'd5, 0);
        step("toidle", 1, 8'h00, 1, 0, 3'd0, 0);
        step("idledone", 1, 8'h00, 1, 0, 3'd0, 0);

        // Full rotation 0..7,0.
        step("rst2", 0, 8'h00, 0, 0, 3'd0, 0);
        step("rot0", 1, 8'hFF, 0, 1, 3'd0, 0);
        for (int k = 1; k <= 8; k++) begin
            step("rot", 1, 8'hFF, 1, 1, 3'(k % 8), 0);
        end

        // Pointer past 5; wrap to 0 then back to 5.
        step("to5", 1, 8'h20, 1, 1, 3'd5, 0);
        step("5to6", 1, 8'hFF, 1, 1, 3'd6, 0);
        step("6to5", 1, 8'h20, 1, 1, 3'd5, 0);
        step("wrap0", 1, 8'h21, 1, 1, 3'd0, 0);
        step("back5", 1, 8'h21, 1, 1, 3'd5, 0);
        step("idle2", 1, 8'h00, 1, 0, 3'd0, 0);

        // Hold limit: grant 3 for 4 BUSY cycles, then timeout and ptr moves to 4.
        step("g3", 1, 8'h08, 0, 1, 3'd3, 0);
        step("hold1", 1, 8'h08, 0, 1, 3'd3, 0);
        step("hold2", 1, 8'h08, 0, 1, 3'd3, 0);
        step("hold3", 1, 8'h08, 0, 1, 3'd3, 0);
        step("tmo", 1, 8'h18, 0, 1, 3'd4, 1);
        step("tmoend", 1, 8'h00, 1, 0, 3'd0, 0);

        // Hold limit coinciding with done: no timeout pulse.
        step("g0", 1, 8'h01, 0, 1, 3'd0, 0);
        step("h0a", 1, 8'h01, 0, 1, 3'd0, 0);
        step("h0b", 1, 8'h01, 0, 1, 3'd0, 0);
        step("h0c", 1, 8'h01, 0, 1, 3'd0, 0);
        step("tmodone", 1, 8'h01, 1, 1, 3'd0, 0);
        step("idle3", 1, 8'h00, 1, 0, 3'd0, 0);

        // Abort: drop request -> IDLE, or hand to next from ptr 2.
        step("g1", 1, 8'h02, 0, 1, 3'd1, 0);
        step("abortidle", 1, 8'h00, 0, 0, 3'd0, 0);
        step("g1b", 1, 8'h02, 0, 1, 3'd1, 0);
        step("abort3", 1, 8'h09, 0, 1, 3'd3, 0);
        step("idle4", 1, 8'h00, 1, 0, 3'd0, 0);

        // Other request bits must not disturb a held grant.
        step("g4", 1, 8'h10, 0, 1, 3'd4, 0);
        step("noise1", 1, 8'h1F, 0, 1, 3'd4, 0);
        step("noise2", 1, 8'h90, 0, 1, 3'd4, 0);
        step("g7", 1, 8'h80, 1, 1, 3'd7, 0);

        // Reset mid-grant, then arbitration restarts from ptr 0.
        step("g6", 1, 8'h40, 1, 1, 3'd6, 0);
        step("rstbusy", 0, 8'h40, 0, 0, 3'd0, 0);
        step("after", 1, 8'hC0, 0, 1, 3'd6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
